// File: rtl/sample_mem_loader.sv
// Byte-stream loader: collects BYTES_PER_SAMPLE pixel bytes plus one label byte per
// sample and writes vector and label to data_mem/label_mem at a shared address.
module sample_mem_loader #(
  parameter int BYTES_PER_SAMPLE = 62,
  parameter int NUM_SAMPLES      = 750,
  parameter int ADDR_W           = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  output logic                          in_ready,
  output logic                          wr_en,
  output logic [ADDR_W-1:0]             wr_addr,
  output logic [BYTES_PER_SAMPLE*8-1:0] wr_data,
  output logic                          label_wr_en,
  output logic [3:0]                    label_data,
  output logic                          busy,
  output logic                          load_done,
  output logic                          label_err
);

  localparam int DATA_W = BYTES_PER_SAMPLE * 8;
  localparam int BCNT_W = $clog2(BYTES_PER_SAMPLE + 1);
  localparam int IDX_W  = $clog2(DATA_W);

  localparam logic [BCNT_W-1:0] LAST_BYTE   = BCNT_W'(BYTES_PER_SAMPLE - 1);
  localparam logic [ADDR_W-1:0] LAST_SAMPLE = ADDR_W'(NUM_SAMPLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    LABEL   = 3'd2,
    WRITE   = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [BCNT_W-1:0] byte_cnt;
  logic [ADDR_W-1:0] sample_cnt;
  logic [IDX_W-1:0]  bit_idx;
  logic              start_run;

  // Start is honoured only when no run is in flight.
  assign start_run = start && (state == IDLE || state == DONE);
  assign bit_idx   = IDX_W'({byte_cnt, 3'b000});
  assign wr_addr   = sample_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the processes are evaluated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    in_ready    = 1'b0;
    wr_en       = 1'b0;
    label_wr_en = 1'b0;
    busy        = 1'b0;
    load_done   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = COLLECT;
      end
      COLLECT: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && byte_cnt == LAST_BYTE) state_nxt = LABEL;
      end
      LABEL: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_nxt = WRITE;
      end
      WRITE: begin
        wr_en       = 1'b1;
        label_wr_en = 1'b1;
        busy        = 1'b1;
        state_nxt   = (sample_cnt == LAST_SAMPLE) ? DONE : COLLECT;
      end
      DONE: begin
        load_done = 1'b1;
        if (start) state_nxt = COLLECT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the wide assembly register is reset as well; it is a flop bank, not a
  // RAM, so clearing it costs nothing and keeps outputs defined out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt   <= '0;
      sample_cnt <= '0;
      wr_data    <= '0;
      label_data <= '0;
      label_err  <= 1'b0;
    end else begin
      if (start_run) begin
        byte_cnt   <= '0;
        sample_cnt <= '0;
        label_err  <= 1'b0;
      end
      unique case (state)
        COLLECT: begin
          if (in_valid) begin
            wr_data[bit_idx +: 8] <= in_data;
            byte_cnt              <= byte_cnt + 1'b1;
          end
        end
        LABEL: begin
          if (in_valid) begin
            label_data <= in_data[3:0];
            if (in_data > 8'd9) label_err <= 1'b1;
          end
        end
        WRITE: begin
          byte_cnt <= '0;
          // Saturate on the final sample so the counter never wraps.
          if (sample_cnt != LAST_SAMPLE) sample_cnt <= sample_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_mem_loader.sv
// Directed bench for sample_mem_loader: reset, single/partial samples, stalls,
// backpressure during WRITE, label error, mid-run reset and a full 750-sample run.
module tb_sample_mem_loader;

  localparam int BPS = 62;
  localparam int NS  = 750;
  localparam int AW  = 10;
  localparam int DW  = BPS * 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          label_wr_en;
  logic [3:0]    label_data;
  logic          busy;
  logic          load_done;
  logic          label_err;

  sample_mem_loader #(
    .BYTES_PER_SAMPLE(BPS),
    .NUM_SAMPLES     (NS),
    .ADDR_W          (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .label_wr_en(label_wr_en),
    .label_data (label_data),
    .busy       (busy),
    .load_done  (load_done),
    .label_err  (label_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            addr;
    logic [DW-1:0] data;
    logic [3:0]    lbl;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   wr_cnt = 0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Every write pulse is matched against the next expected sample in order.
  always @(negedge clk) begin
    if (wr_en || label_wr_en) begin
      check("strobe_pair", 512'(wr_en), 512'(label_wr_en));
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check("spurious_wr", 512'(wr_addr), '1);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 512'(wr_addr), 512'(mon_e.addr));
        check("wr_data", 512'(wr_data), 512'(mon_e.data));
        check("label_data", 512'(label_data), 512'(mon_e.lbl));
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("ready_timeout", 512'(in_ready), 512'(1));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Byte k = base + k*step (byte 0 forced to 0xAA when aa_first). stop_after >= 0
  // sends only that many pixel bytes and no label; start_at >= 0 pulses start there.
  task automatic send_sample(input int addr, input logic [7:0] base, input logic [7:0] step,
                             input logic [7:0] lbl, input int gap_max, input int stop_after,
                             input int start_at, input bit aa_first);
    logic [DW-1:0] v;
    logic [7:0]    b;
    exp_t          e;
    int            n;
    n = (stop_after >= 0) ? stop_after : BPS;
    for (int k = 0; k < BPS; k++) begin
      b = base + 8'(k) * step;
      if (k == 0 && aa_first) b = 8'hAA;
      v[8*k +: 8] = b;
    end
    for (int k = 0; k < n; k++) begin
      if (k == start_at) pulse_start();
      send_byte(v[8*k +: 8], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
    end
    if (stop_after < 0) begin
      e.addr = addr;
      e.data = v;
      e.lbl  = lbl[3:0];
      exp_q.push_back(e);
      send_byte(lbl, 0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, want run completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 512'(in_ready), 512'(0));
    check("rst_wr_en", 512'(wr_en), 512'(0));
    check("rst_label_wr_en", 512'(label_wr_en), 512'(0));
    check("rst_busy", 512'(busy), 512'(0));
    check("rst_load_done", 512'(load_done), 512'(0));
    check("rst_label_err", 512'(label_err), 512'(0));
    check("rst_wr_addr", 512'(wr_addr), 512'(0));
    check("rst_wr_data", 512'(wr_data), 512'(0));
    check("rst_label_data", 512'(label_data), 512'(0));
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 512'(in_ready), 512'(0));
    check("idle_busy", 512'(busy), 512'(0));
    in_valid = 1'b0;

    // Run A: first sample 0x00..0x3D label 7, a few stalled samples, reset mid sample 5.
    pulse_start();
    check("start_busy", 512'(busy), 512'(1));
    check("start_in_ready", 512'(in_ready), 512'(1));
    send_sample(0, 8'h00, 8'h01, 8'h07, 0, -1, -1, 1'b0);
    @(negedge clk);
    check("a0_wr_en", 512'(wr_en), 512'(1));
    check("a0_wr_addr", 512'(wr_addr), 512'(0));
    check("a0_byte0", 512'(wr_data[7:0]), 512'(8'h00));
    check("a0_byte61", 512'(wr_data[495:488]), 512'(8'h3D));
    check("a0_label", 512'(label_data), 512'(7));
    check("a0_ready_in_write", 512'(in_ready), 512'(0));
    check("a0_busy_in_write", 512'(busy), 512'(1));
    for (int s = 1; s < 5; s++)
      send_sample(s, 8'(s * 16), 8'h03, 8'(s), 3, -1, -1, 1'b0);
    send_sample(5, 8'h50, 8'h03, 8'h05, 0, 31, -1, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_wr_cnt", 512'(wr_cnt), 512'(5));
    check("midrst_busy", 512'(busy), 512'(0));
    check("midrst_wr_addr", 512'(wr_addr), 512'(0));
    rst = 1'b0;
    @(negedge clk);

    // Run B: full 750-sample run with label error, backpressure and ignored start.
    wr_cnt = 0;
    pulse_start();
    for (int s = 0; s < NS; s++) begin
      send_sample(s, 8'(s * 7), 8'((s % 5) + 1), (s == 0) ? 8'h0C : 8'(s % 10),
                  (s < 3) ? 2 : 0, -1, (s == 100) ? 10 : -1, (s == 3));
      if (s == 0) begin
        @(negedge clk);
        check("lerr_set", 512'(label_err), 512'(1));
        check("lerr_label", 512'(label_data), 512'(4'hC));
        check("lerr_wr_en", 512'(wr_en), 512'(1));
      end
      if (s == 2) begin
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        check("bp_ready_in_write", 512'(in_ready), 512'(0));
        check("bp_wr_en", 512'(wr_en), 512'(1));
      end
      if (s == NS - 1) begin
        @(negedge clk);
        check("last_wr_addr", 512'(wr_addr), 512'(NS - 1));
        check("last_not_done", 512'(load_done), 512'(0));
        @(negedge clk);
        check("done_load_done", 512'(load_done), 512'(1));
        check("done_busy", 512'(busy), 512'(0));
        check("done_in_ready", 512'(in_ready), 512'(0));
      end
    end
    check("full_wr_cnt", 512'(wr_cnt), 512'(NS));
    check("lerr_sticky", 512'(label_err), 512'(1));
    in_valid = 1'b1;
    in_data  = 8'h11;
    repeat (2) @(negedge clk);
    check("done_hold", 512'(load_done), 512'(1));
    check("done_no_write", 512'(wr_cnt), 512'(NS));
    in_valid = 1'b0;

    // Run C: restart from DONE clears flags and writes from address 0 again.
    wr_cnt = 0;
    pulse_start();
    check("restart_lerr", 512'(label_err), 512'(0));
    check("restart_done", 512'(load_done), 512'(0));
    check("restart_busy", 512'(busy), 512'(1));
    check("restart_addr", 512'(wr_addr), 512'(0));
    send_sample(0, 8'h20, 8'h05, 8'h03, 0, -1, -1, 1'b0);
    repeat (2) @(negedge clk);
    check("c_wr_cnt", 512'(wr_cnt), 512'(1));
    check("c_lerr_clear", 512'(label_err), 512'(0));
    check("queue_drained", 512'(exp_q.size()), 512'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sample_mem_loader.md
Name: sample_mem_loader

Overview:
- Writer side of the sample/label memory interface: accepts a byte stream over valid/ready and assembles 62-byte input vectors plus 4-bit labels.
- Writes each assembled vector into the data memory and its label into the label memory, at the same 10-bit address the processor later reads.
- Sits in front of data_mem/label_mem; asserts load_done when every sample is stored so the controller can be released.

Parameters:
- BYTES_PER_SAMPLE, 62, pixel bytes per sample; sets the vector width to BYTES_PER_SAMPLE*8 = 496.
- NUM_SAMPLES, 750, number of samples loaded per run (must be ≤ 2^ADDR_W).
- ADDR_W, 10, memory address width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; begins a load run at address 0
- in_valid  input  1  in_data holds a valid byte
- in_data  input  8  stream byte: 62 pixel bytes, then 1 label byte per sample
- in_ready  output  1  loader accepts a byte this cycle
- wr_en  output  1  data memory write strobe
- wr_addr  output  ADDR_W  shared write address for both memories
- wr_data  output  BYTES_PER_SAMPLE*8  assembled vector
- label_wr_en  output  1  label memory write strobe
- label_data  output  4  label value
- busy  output  1  run in progress
- load_done  output  1  all NUM_SAMPLES written
- label_err  output  1  sticky flag: a label byte was greater than 9

Behaviour:
- Reset (async): state IDLE. Byte counter, sample counter, wr_addr, wr_data, label_data and all strobes/flags are 0.
- A byte transfers only on a rising edge where in_valid && in_ready. in_ready is combinational from state only, never from in_valid.
- States:
  - IDLE: in_ready=0. start → COLLECT; clears sample counter, byte counter and label_err.
  - COLLECT: in_ready=1. Accepted byte k (0-based) goes to wr_data[8k+7:8k]. Transfer of byte BYTES_PER_SAMPLE-1 → LABEL.
  - LABEL: in_ready=1. On transfer, label_data ← in_data[3:0]. If in_data > 9, label_err ← 1; the write still proceeds. Then → WRITE.
  - WRITE: in_ready=0. wr_en=label_wr_en=1 for exactly this one cycle; wr_addr = sample counter. Next edge: sample counter +1, byte counter 0. If the sample just written was NUM_SAMPLES-1 → DONE, else → COLLECT.
  - DONE: load_done=1, in_ready=0; held until start (→ COLLECT, load_done cleared) or rst.
- busy = 1 in COLLECT, LABEL and WRITE.
- wr_data and label_data hold stable from the end of LABEL through the WRITE cycle. They are don't-care outside WRITE.
- Latency: the label byte is accepted at edge N; wr_en is high during cycle N+1; the next pixel byte can be accepted at edge N+2.
- start while busy=1: ignored.
- in_valid while in_ready=0: no transfer, no state change; the byte is left for the source to hold.
- Stalls (in_valid=0) can occur at any byte; the counters simply hold.
- Reset mid-sample: the partial sample is discarded and nothing is written. Memory contents already written are untouched.
- Sample counter does not wrap; the run stops at NUM_SAMPLES.
- label_err stays set until the next start or rst.

Test Plan:
- Reset/idle: hold rst 3 cycles with in_valid=1 → all outputs 0, in_ready=0, no strobes.
- Single sample (NUM_SAMPLES=1): start, then bytes 0x00..0x3D and label 0x07 with valid held high → one wr_en/label_wr_en pulse at wr_addr=0, wr_data[7:0]=0x00, wr_data[495:488]=0x3D, label_data=7, load_done=1 the next cycle, busy=0.
- Backpressure/stall: random in_valid gaps plus in_valid=1 during WRITE (byte 0xAA presented) → 0xAA not consumed until COLLECT; it appears as byte 0 of the next sample.
- Full run (NUM_SAMPLES=750): 750×63 bytes → exactly 750 write pulses at addresses 0..749 in order, then load_done=1; a start pulse mid-run causes no restart.
- Label error: label byte 0x0C → label_err=1, label_data=0xC, write still occurs; next start clears label_err.
- Reset mid-operation: rst after byte 30 of sample 5 → no write at address 5; after start, the first write is at address 0.
